// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman decode datapath.
package huff_pkg;
  localparam int SIZE_W = 4;
  localparam int RUN_W  = 4;

  localparam logic [RUN_W-1:0]  EOB_RUN  = '0;
  localparam logic [SIZE_W-1:0] EOB_SIZE = '0;

  typedef enum logic [1:0] {
    ST_CODE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_COEFF  = 2'd2,
    ST_OUT    = 2'd3
  } state_e;
endpackage

// File: rtl/huff_coeff_sr.sv
// Coefficient shift register: MSB-first capture with JPEG sign decoding
// (all-ones preset for a leading 0 bit, then +1 on the final bit).
module huff_coeff_sr #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         zero_i,
  input  logic         preset_i,
  input  logic         shift_i,
  input  logic         first_i,
  input  logic         last_i,
  input  logic         bit_i,
  output logic [W-1:0] value_o
);
  logic [W-1:0] sr_q, sr_d;
  logic         neg_q, neg_d;

  assign neg_d = first_i ? ~bit_i : neg_q;

  always_comb begin
    sr_d = {sr_q[W-2:0], bit_i};
    if (first_i && bit_i)
      sr_d = W'(1);
    // Negative values land one below target after the preset shift.
    if (last_i && neg_d)
      sr_d = sr_d + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      neg_q <= 1'b0;
    end else if (zero_i) begin
      sr_q  <= '0;
      neg_q <= 1'b0;
    end else if (preset_i) begin
      sr_q  <= '1;
      neg_q <= 1'b0;
    end else if (shift_i) begin
      sr_q  <= sr_d;
      neg_q <= neg_d;
    end
  end

  assign value_o = sr_q;
endmodule

// File: rtl/huff_decode_dp.sv
// Huffman symbol decoder: canonical-limit code match, Table 2 lookup, coefficient
// capture and a valid/ready output pair. HUFF_EOB_DETECT_EN enables eob_s1.
module huff_decode_dp
  import huff_pkg::*;
#(
  parameter int CODE_W    = 9,
  parameter int COEFF_W   = 11,
  parameter int T2_ADDR_W = 6,
  parameter int LEN_W     = $clog2(CODE_W+1)
) (
  input  logic                 phi1,
  input  logic                 reset,
  input  logic                 bitstream_s1,
  input  logic                 bit_valid_s1,
  output logic                 bit_ready_s1,
  output logic [LEN_W-1:0]     t1_addr_s1,
  input  logic [CODE_W:0]      limit_v1,
  input  logic [T2_ADDR_W-1:0] base_v1,
  output logic [T2_ADDR_W-1:0] t2_addr_s1,
  input  logic [3:0]           coeff_size_v1,
  input  logic [3:0]           run_length_v1,
  output logic                 coeff_valid_s1,
  input  logic                 coeff_ready_s1,
  output logic [COEFF_W-1:0]   coefficient_s1,
  output logic [3:0]           run_length_s1,
  output logic                 eob_s1,
  output logic                 err_s1
);
  state_e               state_q;
  logic [LEN_W-1:0]     len_q;
  logic [CODE_W-1:0]    code_q;
  logic [T2_ADDR_W-1:0] t2_addr_q;
  logic [SIZE_W-1:0]    size_q, cnt_q;
  logic [RUN_W-1:0]     run_q;
  logic                 valid_q, err_q;

  logic [CODE_W:0] cand;
  logic            match, last_len, too_big, beat;

  assign cand     = {code_q, bitstream_s1};
  assign match    = cand < limit_v1;
  assign last_len = (len_q == LEN_W'(CODE_W-1));
  assign too_big  = int'(coeff_size_v1) > (COEFF_W - 1);

  assign bit_ready_s1 = (state_q == ST_CODE) || (state_q == ST_COEFF);
  assign beat         = bit_valid_s1 && bit_ready_s1;
  assign t1_addr_s1   = len_q + LEN_W'(1);

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CODE;
      len_q     <= '0;
      code_q    <= '0;
      t2_addr_q <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
      run_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        ST_CODE: if (beat) begin
          if (match) begin
            t2_addr_q <= base_v1 + cand[T2_ADDR_W-1:0];
            len_q     <= '0;
            code_q    <= '0;
            state_q   <= ST_LOOKUP;
          end else if (last_len) begin
            err_q  <= 1'b1;
            len_q  <= '0;
            code_q <= '0;
          end else begin
            code_q <= cand[CODE_W-1:0];
            len_q  <= len_q + LEN_W'(1);
          end
        end
        ST_LOOKUP: begin
          size_q <= coeff_size_v1;
          cnt_q  <= coeff_size_v1;
          run_q  <= run_length_v1;
          if (coeff_size_v1 == '0) begin
            valid_q <= 1'b1;
            state_q <= ST_OUT;
          end else if (too_big) begin
            err_q   <= 1'b1;
            state_q <= ST_CODE;
          end else begin
            state_q <= ST_COEFF;
          end
        end
        ST_COEFF: if (beat) begin
          cnt_q <= cnt_q - SIZE_W'(1);
          if (cnt_q == SIZE_W'(1)) begin
            valid_q <= 1'b1;
            state_q <= ST_OUT;
          end
        end
        ST_OUT: if (coeff_ready_s1) begin
          valid_q <= 1'b0;
          state_q <= ST_CODE;
        end
        default: state_q <= ST_CODE;
      endcase
    end
  end

  huff_coeff_sr #(.W(COEFF_W)) u_coeff_sr (
    .clk_i    (phi1),
    .rst_i    (reset),
    .zero_i   (state_q == ST_LOOKUP && coeff_size_v1 == '0),
    .preset_i (state_q == ST_LOOKUP && coeff_size_v1 != '0),
    .shift_i  (state_q == ST_COEFF && beat),
    .first_i  (cnt_q == size_q),
    .last_i   (cnt_q == SIZE_W'(1)),
    .bit_i    (bitstream_s1),
    .value_o  (coefficient_s1)
  );

`ifdef HUFF_EOB_DETECT_EN
  logic eob_q;
  // Decided at lookup so it travels with the pair it describes.
  always_ff @(posedge phi1 or posedge reset) begin
    if (reset)
      eob_q <= 1'b0;
    else if (state_q == ST_LOOKUP)
      eob_q <= (coeff_size_v1 == EOB_SIZE) && (run_length_v1 == EOB_RUN);
    else if (state_q == ST_OUT && coeff_ready_s1)
      eob_q <= 1'b0;
  end
  assign eob_s1 = eob_q;
`else
  assign eob_s1 = 1'b0;
`endif

  assign t2_addr_s1     = t2_addr_q;
  assign run_length_s1  = run_q;
  assign coeff_valid_s1 = valid_q;
  assign err_s1         = err_q;
endmodule

// File: tb/tb_huff_decode_dp.sv
// Directed bench for huff_decode_dp with the test-plan Table 1 and a small Table 2.
module tb_huff_decode_dp;
  localparam int CODE_W = 9, COEFF_W = 11, T2_ADDR_W = 6, LEN_W = 4;

  logic phi1 = 1'b0, reset = 1'b1;
  logic bitstream_s1 = 1'b0, bit_valid_s1 = 1'b0, coeff_ready_s1 = 1'b0;
  logic bit_ready_s1, coeff_valid_s1, eob_s1, err_s1;
  logic [LEN_W-1:0]     t1_addr_s1;
  logic [CODE_W:0]      limit_v1;
  logic [T2_ADDR_W-1:0] base_v1, t2_addr_s1;
  logic [3:0]           coeff_size_v1, run_length_v1, run_length_s1;
  logic [COEFF_W-1:0]   coefficient_s1;

  logic [3:0] t2_run [64];
  logic [3:0] t2_size [64];
  int n_chk = 0, n_fail = 0;
  logic exp_eob;

  always #5 phi1 = ~phi1;

  huff_decode_dp dut (
    .phi1(phi1), .reset(reset), .bitstream_s1(bitstream_s1), .bit_valid_s1(bit_valid_s1),
    .bit_ready_s1(bit_ready_s1), .t1_addr_s1(t1_addr_s1), .limit_v1(limit_v1), .base_v1(base_v1),
    .t2_addr_s1(t2_addr_s1), .coeff_size_v1(coeff_size_v1), .run_length_v1(run_length_v1),
    .coeff_valid_s1(coeff_valid_s1), .coeff_ready_s1(coeff_ready_s1),
    .coefficient_s1(coefficient_s1), .run_length_s1(run_length_s1), .eob_s1(eob_s1), .err_s1(err_s1)
  );

  always_comb begin
    limit_v1 = '0;
    base_v1  = '0;
    case (t1_addr_s1)
      4'd2: begin limit_v1 = 10'd1; base_v1 = 6'd0;  end
      4'd3: begin limit_v1 = 10'd4; base_v1 = 6'd63; end
      default: ;
    endcase
    coeff_size_v1 = t2_size[t2_addr_s1];
    run_length_v1 = t2_run[t2_addr_s1];
  end

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bitstream_s1 = b;
    bit_valid_s1 = 1'b1;
    while (!bit_ready_s1 && n < 20) begin
      @(posedge phi1); #1;
      n++;
    end
    if (n == 20) begin
      n_chk++; n_fail++;
      $display("FAIL send_bit_timeout: bit_ready_s1 got 0 want 1 within 20 cycles");
    end else begin
      @(posedge phi1); #1;
    end
    bit_valid_s1 = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic take;
    coeff_ready_s1 = 1'b1;
    @(posedge phi1); #1;
    coeff_ready_s1 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge phi1);
    #1;
    n_chk++; if (bit_ready_s1 !== 1'b1) begin n_fail++; $display("FAIL rst_bit_ready: got %0h want 1", bit_ready_s1); end
    n_chk++; if (t1_addr_s1 !== 4'd1) begin n_fail++; $display("FAIL rst_t1_addr: got %0h want 1", t1_addr_s1); end
    n_chk++; if (t2_addr_s1 !== 6'd0) begin n_fail++; $display("FAIL rst_t2_addr: got %0h want 0", t2_addr_s1); end
    n_chk++; if (coeff_valid_s1 !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h want 0", coeff_valid_s1); end
    n_chk++; if (coefficient_s1 !== 11'd0) begin n_fail++; $display("FAIL rst_coeff: got %0h want 0", coefficient_s1); end
    n_chk++; if (err_s1 !== 1'b0 || eob_s1 !== 1'b0 || run_length_s1 !== 4'd0) begin
      n_fail++; $display("FAIL rst_misc: got err %0h eob %0h run %0h want 0 0 0", err_s1, eob_s1, run_length_s1); end
    reset = 1'b0;
  endtask

  task automatic test_eob;
    send_bit(1'b0);
    n_chk++; if (t1_addr_s1 !== 4'd2) begin n_fail++; $display("FAIL eob_t1_addr: got %0h want 2", t1_addr_s1); end
    send_bit(1'b0);
    n_chk++; if (t2_addr_s1 !== 6'd0) begin n_fail++; $display("FAIL eob_t2_addr: got %0h want 0", t2_addr_s1); end
    n_chk++; if (coeff_valid_s1 !== 1'b0 || bit_ready_s1 !== 1'b0) begin
      n_fail++; $display("FAIL eob_lookup: got valid %0h ready %0h want 0 0", coeff_valid_s1, bit_ready_s1); end
    @(posedge phi1); #1;
    n_chk++; if (coeff_valid_s1 !== 1'b1) begin n_fail++; $display("FAIL eob_valid: got %0h want 1", coeff_valid_s1); end
    n_chk++; if (coefficient_s1 !== 11'd0 || run_length_s1 !== 4'd0) begin
      n_fail++; $display("FAIL eob_pair: got coeff %0h run %0h want 0 0", coefficient_s1, run_length_s1); end
    n_chk++; if (eob_s1 !== exp_eob) begin n_fail++; $display("FAIL eob_flag: got %0h want %0h", eob_s1, exp_eob); end
    take();
    n_chk++; if (coeff_valid_s1 !== 1'b0 || eob_s1 !== 1'b0) begin
      n_fail++; $display("FAIL eob_release: got valid %0h eob %0h want 0 0", coeff_valid_s1, eob_s1); end
  endtask

  task automatic test_positive;
    send_bits(16'b010, 3);
    n_chk++; if (t2_addr_s1 !== 6'd1) begin n_fail++; $display("FAIL pos_t2_addr: got %0h want 1", t2_addr_s1); end
    send_bits(16'b101, 3);
    n_chk++; if (coeff_valid_s1 !== 1'b1) begin n_fail++; $display("FAIL pos_valid: got %0h want 1", coeff_valid_s1); end
    n_chk++; if (coefficient_s1 !== 11'd5) begin n_fail++; $display("FAIL pos_coeff: got %0h want 5", coefficient_s1); end
    n_chk++; if (run_length_s1 !== 4'd3 || eob_s1 !== 1'b0) begin
      n_fail++; $display("FAIL pos_run: got run %0h eob %0h want 3 0", run_length_s1, eob_s1); end
    take();
  endtask

  task automatic test_negative;
    send_bits(16'b011, 3);
    n_chk++; if (t2_addr_s1 !== 6'd2) begin n_fail++; $display("FAIL neg_t2_addr: got %0h want 2", t2_addr_s1); end
    send_bits(16'b01, 2);
    n_chk++; if (coeff_valid_s1 !== 1'b1 || coefficient_s1 !== 11'h7FE) begin
      n_fail++; $display("FAIL neg_coeff: got valid %0h coeff %0h want 1 7fe", coeff_valid_s1, coefficient_s1); end
    n_chk++; if (run_length_s1 !== 4'd0 || eob_s1 !== 1'b0) begin
      n_fail++; $display("FAIL neg_run: got run %0h eob %0h want 0 0", run_length_s1, eob_s1); end
    take();
  endtask

  task automatic test_stall;
    send_bits(16'b010101, 6);
    bit_valid_s1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bitstream_s1 = i[0];
      @(posedge phi1); #1;
      n_chk++; if (coeff_valid_s1 !== 1'b1 || coefficient_s1 !== 11'd5 || run_length_s1 !== 4'd3 || bit_ready_s1 !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: got valid %0h coeff %0h run %0h ready %0h want 1 5 3 0",
                           i, coeff_valid_s1, coefficient_s1, run_length_s1, bit_ready_s1); end
    end
    coeff_ready_s1 = 1'b1;
    @(posedge phi1); #1;
    coeff_ready_s1 = 1'b0;
    bit_valid_s1 = 1'b0;
    n_chk++; if (coeff_valid_s1 !== 1'b0 || t1_addr_s1 !== 4'd1) begin
      n_fail++; $display("FAIL stall_done: got valid %0h t1_addr %0h want 0 1", coeff_valid_s1, t1_addr_s1); end
  endtask

  task automatic test_code_overflow;
    for (int i = 1; i <= 9; i++) begin
      send_bit(1'b1);
      n_chk++; if (err_s1 !== (i == 9)) begin n_fail++; $display("FAIL ovf_err_beat%0d: got %0h want %0h", i, err_s1, (i == 9)); end
      if (i == 8) begin
        n_chk++; if (t1_addr_s1 !== 4'd9) begin n_fail++; $display("FAIL ovf_t1_addr: got %0h want 9", t1_addr_s1); end
      end
    end
    @(posedge phi1); #1;
    n_chk++; if (err_s1 !== 1'b0 || t1_addr_s1 !== 4'd1) begin
      n_fail++; $display("FAIL ovf_recover: got err %0h t1_addr %0h want 0 1", err_s1, t1_addr_s1); end
    send_bits(16'b00, 2);
    @(posedge phi1); #1;
    n_chk++; if (coeff_valid_s1 !== 1'b1 || coefficient_s1 !== 11'd0 || run_length_s1 !== 4'd0) begin
      n_fail++; $display("FAIL ovf_next: got valid %0h coeff %0h run %0h want 1 0 0", coeff_valid_s1, coefficient_s1, run_length_s1); end
    take();
  endtask

  task automatic test_size_limits;
    t2_size[2] = 4'd11;
    send_bits(16'b011, 3);
    n_chk++; if (err_s1 !== 1'b0) begin n_fail++; $display("FAIL big_err_early: got %0h want 0", err_s1); end
    @(posedge phi1); #1;
    n_chk++; if (err_s1 !== 1'b1 || coeff_valid_s1 !== 1'b0 || bit_ready_s1 !== 1'b1) begin
      n_fail++; $display("FAIL big_err: got err %0h valid %0h ready %0h want 1 0 1", err_s1, coeff_valid_s1, bit_ready_s1); end
    @(posedge phi1); #1;
    n_chk++; if (err_s1 !== 1'b0) begin n_fail++; $display("FAIL big_err_pulse: got %0h want 0", err_s1); end
    t2_size[2] = 4'd10;
    send_bits(16'b011, 3);
    send_bits(16'b10_0000_0000, 10);
    n_chk++; if (coeff_valid_s1 !== 1'b1 || coefficient_s1 !== 11'h200) begin
      n_fail++; $display("FAIL max_pos: got valid %0h coeff %0h want 1 200", coeff_valid_s1, coefficient_s1); end
    take();
    send_bits(16'b011, 3);
    send_bits(16'b00_0000_0000, 10);
    n_chk++; if (coeff_valid_s1 !== 1'b1 || coefficient_s1 !== 11'h401) begin
      n_fail++; $display("FAIL max_neg: got valid %0h coeff %0h want 1 401", coeff_valid_s1, coefficient_s1); end
    take();
    t2_size[2] = 4'd2;
  endtask

  task automatic test_reset_mid;
    send_bits(16'b0101, 4);
    #2 reset = 1'b1;
    #1;
    n_chk++; if (bit_ready_s1 !== 1'b1 || t1_addr_s1 !== 4'd1 || t2_addr_s1 !== 6'd0) begin
      n_fail++; $display("FAIL mid_rst_ctrl: got ready %0h t1 %0h t2 %0h want 1 1 0", bit_ready_s1, t1_addr_s1, t2_addr_s1); end
    n_chk++; if (coeff_valid_s1 !== 1'b0 || coefficient_s1 !== 11'd0 || run_length_s1 !== 4'd0 || err_s1 !== 1'b0 || eob_s1 !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_out: got valid %0h coeff %0h run %0h err %0h eob %0h want all 0",
                         coeff_valid_s1, coefficient_s1, run_length_s1, err_s1, eob_s1); end
    @(posedge phi1); #1;
    reset = 1'b0;
    send_bits(16'b01101, 5);
    n_chk++; if (coeff_valid_s1 !== 1'b1 || coefficient_s1 !== 11'h7FE || run_length_s1 !== 4'd0) begin
      n_fail++; $display("FAIL mid_rst_next: got valid %0h coeff %0h run %0h want 1 7fe 0", coeff_valid_s1, coefficient_s1, run_length_s1); end
    take();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      t2_run[i]  = 4'd0;
      t2_size[i] = 4'd0;
    end
    t2_run[1]  = 4'd3;
    t2_size[1] = 4'd3;
    t2_size[2] = 4'd2;
`ifdef HUFF_EOB_DETECT_EN
    exp_eob = 1'b1;
`else
    exp_eob = 1'b0;
`endif
    test_reset();
    test_eob();
    test_positive();
    test_negative();
    test_stall();
    test_code_overflow();
    test_size_limits();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/huff_decode_dp.md
# huff_decode_dp

Parametrised Huffman symbol decoder datapath with an integrated control FSM: it shifts in the JPEG bitstream one bit per accepted beat and determines the code length by canonical-limit comparison against Table 1. It then forms the Table 2 address, reads run length and coefficient size, and shifts in and sign-decodes the coefficient. A registered (run, coefficient) pair is presented to the downstream block through a valid/ready handshake. It replaces the fixed 9-bit / 10-bit two-phase datapath and its separate controller.

## Interface
- CODE_W, 9: maximum Huffman code length in bits.
- COEFF_W, 11: signed coefficient output width; largest legal size is COEFF_W-1.
- T2_ADDR_W, 6: Table 2 address width.
- LEN_W, $clog2(CODE_W+1): code-length counter width.
- phi1  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- bitstream_s1  in  1  serial bit.
- bit_valid_s1  in  1  bitstream_s1 is valid.
- bit_ready_s1  out  1  block accepts a bit this cycle.
- t1_addr_s1  out  LEN_W  code length queried in Table 1; equals len_q+1.
- limit_v1  in  CODE_W+1  Table 1 exclusive bound: one past the largest code of that length; 0 means no codes.
- base_v1  in  T2_ADDR_W  Table 1 base offset.
- t2_addr_s1  out  T2_ADDR_W  registered Table 2 address.
- coeff_size_v1  in  4  Table 2 coefficient size.
- run_length_v1  in  4  Table 2 run length.
- coeff_valid_s1  out  1  output pair is valid.
- coeff_ready_s1  in  1  downstream accepts the pair.
- coefficient_s1  out  COEFF_W  signed decoded coefficient.
- run_length_s1  out  4  run length.
- eob_s1  out  1  end-of-block marker (see Configuration).
- err_s1  out  1  one-cycle error pulse.

## Operation
- Tables 1 and 2 are combinational ROMs. They respond in the same cycle as their address.
- FSM states: CODE, LOOKUP, COEFF, OUT.
- bit_ready_s1 = (state==CODE || state==COEFF). It depends on state only.
- A beat is accepted when bit_valid_s1 && bit_ready_s1.
- **CODE**:
  - On each beat, cand = {code_q, bit} (zero-extended).
  - match = cand < limit_v1.
  - On match: register t2_addr = base_v1 + cand[T2_ADDR_W-1:0], computed modulo 2^T2_ADDR_W. Clear len/code and go to LOOKUP.
  - With no match and len_q+1 < CODE_W: code_q <= cand, len_q++.
  - With no match and len_q+1 == CODE_W: pulse err_s1, clear len/code, stay in CODE.
- **LOOKUP**: latch coeff_size_v1 and run_length_v1.
  - Size 0: coefficient = 0; go to OUT.
  - Size > COEFF_W-1: pulse err_s1, go to CODE.
  - Otherwise: go to COEFF.
- **COEFF**: shift exactly size bits, MSB first. After the last bit, go to OUT.
  - If the first bit is 1: coefficient = zero-extended bits.
  - If the first bit is 0: coefficient = bits − (2^size − 1), in two's complement. Implement as an all-ones preset, then shift, then +1.
- **OUT**: coeff_valid_s1 = 1. coefficient_s1, run_length_s1 and eob_s1 are held stable until coeff_ready_s1. On the handshake, go to CODE.
- Simultaneous events:
  - bit_valid_s1 is ignored outside CODE/COEFF.
  - coeff_ready_s1 is ignored outside OUT.

## Timing
- Reset, asynchronous, entered at any point including mid-code or mid-coefficient:
  - state = CODE; len/code/shift registers = 0.
  - All outputs 0 except bit_ready_s1 = 1; t1_addr_s1 = 1.
  - Any partial symbol is discarded.
- Size 0: coeff_valid_s1 rises 2 cycles after the edge that accepts the final code bit.
- Size > 0: coeff_valid_s1 rises 1 cycle after the edge that accepts the final coefficient bit.
- Throughput: maximum one bit per cycle. LOOKUP and OUT each cost at least one bubble cycle per symbol.
- err_s1 is high for exactly one cycle.

## Configuration
- HUFF_EOB_DETECT_EN defined: eob_s1 = 1 in OUT when run=0 and size=0. It is registered with the pair.
- HUFF_EOB_DETECT_EN undefined: eob_s1 is tied to 0 and no comparison logic is built. EOB is still emitted as a (run 0, coefficient 0) pair.

## Structure
- Package huff_pkg holds:
  - the FSM state encoding;
  - SIZE_W = 4 and RUN_W = 4;
  - the EOB run/size constants.
- Sub-module huff_coeff_sr holds the COEFF_W shift register, the sign-preset logic and the +1 correction. It is instantiated once.
- FSM, comparator and address adder live in the top module.

## Test plan
Table 1 setup for all scenarios:
- L1: limit 0.
- L2: limit 1, base 0.
- L3: limit 4, base 63.
- All other lengths: limit 0.

Scenarios:
- Reset asserted mid-COEFF for 1 cycle -> all outputs 0, bit_ready_s1=1, t1_addr_s1=1; the next decode starts from a fresh code.
- Bits 0,0 with T2[0] = run 0, size 0 -> t2_addr_s1=0; coeff_valid_s1 is asserted 2 cycles after the 2nd bit with coefficient 0. eob_s1=1 only when HUFF_EOB_DETECT_EN is defined.
- Bits 0,1,0 then 1,0,1 with T2[1] = run 3, size 3 -> t2_addr_s1=1; coefficient_s1=+5, run_length_s1=3.
- Bits 0,1,1 then 0,1 with T2[2] = run 0, size 2 -> coefficient_s1 = −2 (11'h7FE).
- coeff_ready_s1 held low 4 cycles in OUT -> outputs stable, bit_ready_s1=0, no bits consumed; completes on the 5th cycle.
- 9 consecutive 1 bits -> err_s1 pulses once on the 9th beat; the next bits 0,0 decode correctly.
